alu_result_fifo: RTL and testbench
==================================

Name: alu_result_fifo

Overview:
- Downstream stage of the 32-bit ALU (alu_32).
- Captures each ALU result together with its carryout, overflow and zero flags and the 4-bit op code that produced it.
- Buffers entries in a DEPTH-entry first-word-fall-through FIFO with valid/ready handshakes on both sides, so the writeback/consumer stage can stall without losing ALU output.
- Maintains sticky status flags for overflow and for illegal op codes.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- CW, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream ALU output is valid this cycle
- in_ready  output  1  FIFO can accept an entry (= !full)
- in_result  input  32  ALU result
- in_carryout  input  1  ALU carryout
- in_overflow  input  1  ALU overflow
- in_zero  input  1  ALU zero flag
- in_op  input  4  op code that produced the result (legal range 4'b0000..4'b1000)
- out_valid  output  1  head entry is valid (= !empty)
- out_ready  input  1  consumer takes the head entry this cycle
- out_result  output  32  head entry result
- out_carryout  output  1  head entry carryout
- out_overflow  output  1  head entry overflow
- out_zero  output  1  head entry zero
- out_op  output  4  head entry op code
- count  output  CW  current occupancy, 0..DEPTH
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- sticky_ovf  output  1  set when an accepted entry has in_overflow=1
- sticky_illegal  output  1  set when an illegal op is presented with in_valid=1 and in_ready=1
- clr_sticky  input  1  synchronous clear of both sticky flags

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, in_ready=1, out_valid=0, sticky_ovf=0, sticky_illegal=0, all storage entries=0. Reset mid-operation discards all contents immediately and does not wait for a clock edge.
- Push:
  - Occurs when in_valid & in_ready with a legal op (in_op <= 4'b1000).
  - Writes {op, zero, overflow, carryout, result} (39 bits) at wr_ptr.
  - wr_ptr increments modulo DEPTH and wraps from DEPTH-1 to 0.
- Illegal op:
  - Condition: in_valid & in_ready & in_op > 4'b1000.
  - The handshake completes but the entry is not written, so it is dropped.
  - sticky_illegal is set. count, pointers and sticky_ovf are unchanged.
- Pop:
  - Occurs when out_valid & out_ready.
  - rd_ptr increments modulo DEPTH and wraps.
  - out_ready while empty has no effect.
- Outputs (FWFT):
  - out_* present the entry at rd_ptr combinationally from storage.
  - out_* are forced to 0 when empty.
- Latency:
  - An entry pushed at edge N is visible on out_* with out_valid=1 after edge N, i.e. one cycle.
  - There is no combinational in-to-out bypass when empty.
- count update:
  - +1 on push only, -1 on pop only.
  - Unchanged on simultaneous push and pop, or when neither occurs.
- Full: in_ready=0 and in_valid is ignored. Upstream must hold its data. A pop while full does not allow a same-cycle push, because in_ready depends only on full.
- Empty with simultaneous push and no pop: count goes 0→1. out_valid rises the next cycle.
- Simultaneous push and pop when 0<count<DEPTH: both pointers advance and count is unchanged.
- Sticky flags:
  - Set on the edge of the qualifying push.
  - clr_sticky clears both flags on the next edge.
  - If set and clear occur in the same cycle, set wins and the flag stays 1.
- full, empty and in_ready are derived from the registered count. They carry no combinational dependence on in_valid or out_ready.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then release → count=0, empty=1, full=0, in_ready=1, out_valid=0, out_result=0, stickies=0.
- Single pass-through: push result=32'h0000_0005, op=4'b0000, carry=0, ovf=0, zero=0; out_ready=1 → out_valid=1 exactly one cycle after the push edge with out_result=32'h5, out_op=0. It pops on the following edge and count returns to 0.
- Fill and stall, DEPTH=4: push 32'h10, 32'h20, 32'h30, 32'h40 with out_ready=0 → count=4, full=1, in_ready=0. A fifth in_valid with 32'h50 is not accepted. Draining yields 10,20,30,40 in order, then 50 once re-presented.
- Wrap-around with concurrent push/pop: hold count=2 and run 10 cycles of in_valid=1 and out_ready=1 → count stays 2, outputs appear in strict push order, and pointers wrap at least twice.
- Sticky flags: push op=4'b0000 with ovf=1 → sticky_ovf=1. Present op=4'b1011 → sticky_illegal=1 and count unchanged. Assert clr_sticky in the same cycle as another ovf=1 push → sticky_ovf stays 1. Then clr_sticky alone → both flags 0.
- Async reset mid-operation: with count=3, assert rst between clock edges → count=0, empty=1 and out_valid=0 immediately, before the next edge. After release, a push of 32'hDEAD_BEEF emerges as the first output.

Source files
------------

// File: rtl/alu_result_fifo.sv
// alu_result_fifo
// ---------------------------------------------------------------------------
// Purpose:
//   Sits downstream of the 32-bit ALU. Each accepted ALU result is stored
//   together with its carryout/overflow/zero flags and the op code that
//   produced it. Entries sit in a first-word-fall-through FIFO so the
//   consumer can stall without losing ALU output. Two sticky status flags
//   record overflow results and illegal op codes.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   upstream handshake (in_ready = !full)
//   in_result, in_carryout, in_overflow, in_zero, in_op
//                         ALU result, flags and op code (legal op 0..8)
//   out_valid / out_ready downstream handshake (out_valid = !empty)
//   out_result, out_carryout, out_overflow, out_zero, out_op
//                         head entry, forced to zero while empty
//   count, full, empty    occupancy status from the registered count
//   sticky_ovf            set when an accepted entry carries overflow
//   sticky_illegal        set when an illegal op completes a handshake
//   clr_sticky            synchronous clear of both sticky flags
// ---------------------------------------------------------------------------
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_result,
  input  logic          in_carryout,
  input  logic          in_overflow,
  input  logic          in_zero,
  input  logic [3:0]    in_op,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_result,
  output logic          out_carryout,
  output logic          out_overflow,
  output logic          out_zero,
  output logic [3:0]    out_op,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          sticky_ovf,
  output logic          sticky_illegal,
  input  logic          clr_sticky
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] MaxLegalOp = 4'b1000;

  // Entry layout: {op[38:35], zero[34], overflow[33], carryout[32], result[31:0]}
  logic [38:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic          r_stickyOvf;
  logic          r_stickyIllegal;

  logic          w_full;
  logic          w_empty;
  logic          w_handshake;
  logic          w_legalOp;
  logic          w_push;
  logic          w_illegal;
  logic          w_pop;
  logic [38:0]   w_head;

  // Status comes only from the registered count, so in_ready/out_valid never
  // depend combinationally on the handshake inputs. An illegal op still
  // completes its handshake but is dropped instead of being written.
  always_comb begin
    w_full      = (r_count == CW'(DEPTH));
    w_empty     = (r_count == '0);
    w_handshake = in_valid & ~w_full;
    w_legalOp   = (in_op <= MaxLegalOp);
    w_push      = w_handshake & w_legalOp;
    w_illegal   = w_handshake & ~w_legalOp;
    w_pop       = out_ready & ~w_empty;
  end

  // Storage write port. Clearing every entry on reset keeps the array in a
  // known state even though the empty-forcing on the outputs would hide it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wrPtr] <= {in_op, in_zero, in_overflow, in_carryout, in_result};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; the count
  // tracks occupancy and stays put when a push and a pop coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as clr_sticky wins, so an event
  // that coincides with the clear is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stickyOvf     <= 1'b0;
      r_stickyIllegal <= 1'b0;
    end else begin
      if (w_push && in_overflow) begin
        r_stickyOvf <= 1'b1;
      end else if (clr_sticky) begin
        r_stickyOvf <= 1'b0;
      end
      if (w_illegal) begin
        r_stickyIllegal <= 1'b1;
      end else if (clr_sticky) begin
        r_stickyIllegal <= 1'b0;
      end
    end
  end

  // First-word-fall-through read: the head entry is shown directly from
  // storage and masked to zero while the FIFO is empty.
  always_comb begin
    w_head       = w_empty ? '0 : r_mem[r_rdPtr];
    out_result   = w_head[31:0];
    out_carryout = w_head[32];
    out_overflow = w_head[33];
    out_zero     = w_head[34];
    out_op       = w_head[38:35];
  end

  assign in_ready       = ~w_full;
  assign out_valid      = ~w_empty;
  assign full           = w_full;
  assign empty          = w_empty;
  assign count          = r_count;
  assign sticky_ovf     = r_stickyOvf;
  assign sticky_illegal = r_stickyIllegal;

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo
// ---------------------------------------------------------------------------
// Purpose:
//   Directed bench for alu_result_fifo (DEPTH=4). Inputs are driven 1 ns
//   after the rising edge and outputs are sampled there too, away from the
//   active edge. Expected values are hand-computed constants, with a small
//   queue holding the expected push order for the wrap-around section.
// ---------------------------------------------------------------------------
module tb_alu_result_fifo;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_result;
  logic          in_carryout;
  logic          in_overflow;
  logic          in_zero;
  logic [3:0]    in_op;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_result;
  logic          out_carryout;
  logic          out_overflow;
  logic          out_zero;
  logic [3:0]    out_op;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          sticky_ovf;
  logic          sticky_illegal;
  logic          clr_sticky;

  int compareCount  = 0;
  int mismatchCount = 0;
  logic [31:0] expQ [$];

  alu_result_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_result      (in_result),
    .in_carryout    (in_carryout),
    .in_overflow    (in_overflow),
    .in_zero        (in_zero),
    .in_op          (in_op),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_carryout   (out_carryout),
    .out_overflow   (out_overflow),
    .out_zero       (out_zero),
    .out_op         (out_op),
    .count          (count),
    .full           (full),
    .empty          (empty),
    .sticky_ovf     (sticky_ovf),
    .sticky_illegal (sticky_illegal),
    .clr_sticky     (clr_sticky)
  );

  // 10 ns free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then wait for the edge and settle 1 ns.
  task automatic applyStimulus(input logic valid, input logic [31:0] result,
                               input logic carry, input logic ovf,
                               input logic zero, input logic [3:0] op,
                               input logic ready, input logic clr);
    in_valid    = valid;
    in_result   = result;
    in_carryout = carry;
    in_overflow = ovf;
    in_zero     = zero;
    in_op       = op;
    out_ready   = ready;
    clr_sticky  = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_result = '0; in_carryout = 1'b0; in_overflow = 1'b0;
    in_zero = 1'b0; in_op = 4'h0; out_ready = 1'b0; clr_sticky = 1'b0;

    // Reset then idle.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset count", 64'(count), 64'd0);
    checkOutput("reset empty", 64'(empty), 64'd1);
    checkOutput("reset full", 64'(full), 64'd0);
    checkOutput("reset in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset out_result", 64'(out_result), 64'd0);
    checkOutput("reset sticky_ovf", 64'(sticky_ovf), 64'd0);
    checkOutput("reset sticky_illegal", 64'(sticky_illegal), 64'd0);

    // Single pass-through: no bypass before the edge, visible right after.
    in_valid = 1'b1; in_result = 32'h5; out_ready = 1'b1;
    #1;
    checkOutput("pass no bypass", 64'(out_valid), 64'd0);
    applyStimulus(1'b1, 32'h5, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    checkOutput("pass out_valid", 64'(out_valid), 64'd1);
    checkOutput("pass out_result", 64'(out_result), 64'h5);
    checkOutput("pass out_op", 64'(out_op), 64'h0);
    checkOutput("pass count", 64'(count), 64'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    checkOutput("pass popped count", 64'(count), 64'd0);
    checkOutput("pass popped empty", 64'(empty), 64'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    checkOutput("pop on empty count", 64'(count), 64'd0);

    // Fill and stall.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 32'(i * 16), 1'b0, 1'b0, 1'b0, 4'h1, 1'b0, 1'b0);
    end
    checkOutput("fill count", 64'(count), 64'd4);
    checkOutput("fill full", 64'(full), 64'd1);
    checkOutput("fill in_ready", 64'(in_ready), 64'd0);
    applyStimulus(1'b1, 32'h50, 1'b0, 1'b0, 1'b0, 4'h1, 1'b0, 1'b0);
    checkOutput("fifth rejected count", 64'(count), 64'd4);
    checkOutput("fifth rejected head", 64'(out_result), 64'h10);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("drain head", 64'(out_result), 64'(i * 16));
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    end
    checkOutput("drained count", 64'(count), 64'd0);
    applyStimulus(1'b1, 32'h50, 1'b0, 1'b0, 1'b0, 4'h1, 1'b0, 1'b0);
    checkOutput("re-presented head", 64'(out_result), 64'h50);
    checkOutput("re-presented op", 64'(out_op), 64'h1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    checkOutput("re-presented popped", 64'(count), 64'd0);

    // Wrap-around with concurrent push and pop at count=2.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0);
      expQ.push_back(32'h100 + 32'(i));
    end
    checkOutput("wrap prefill count", 64'(count), 64'd2);
    for (int i = 0; i < 10; i++) begin
      checkOutput("wrap head", 64'(out_result), 64'(expQ[0]));
      applyStimulus(1'b1, 32'h102 + 32'(i), 1'b0, 1'b0, 1'b0, 4'h2, 1'b1, 1'b0);
      void'(expQ.pop_front());
      expQ.push_back(32'h102 + 32'(i));
      checkOutput("wrap count", 64'(count), 64'd2);
    end
    for (int i = 0; i < 2; i++) begin
      checkOutput("wrap drain head", 64'(out_result), 64'(expQ[0]));
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
      void'(expQ.pop_front());
    end
    checkOutput("wrap drained", 64'(count), 64'd0);

    // Sticky flags.
    applyStimulus(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("sticky_ovf set", 64'(sticky_ovf), 64'd1);
    checkOutput("sticky_illegal clear", 64'(sticky_illegal), 64'd0);
    checkOutput("ovf head overflow", 64'(out_overflow), 64'd1);
    applyStimulus(1'b1, 32'h1234, 1'b0, 1'b0, 1'b0, 4'hB, 1'b0, 1'b0);
    checkOutput("sticky_illegal set", 64'(sticky_illegal), 64'd1);
    checkOutput("illegal count", 64'(count), 64'd1);
    applyStimulus(1'b1, 32'h0, 1'b1, 1'b1, 1'b1, 4'h8, 1'b0, 1'b1);
    checkOutput("set beats clear ovf", 64'(sticky_ovf), 64'd1);
    checkOutput("clear illegal", 64'(sticky_illegal), 64'd0);
    checkOutput("op 8 legal count", 64'(count), 64'd2);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    checkOutput("clear alone ovf", 64'(sticky_ovf), 64'd0);
    checkOutput("clear alone illegal", 64'(sticky_illegal), 64'd0);
    checkOutput("sticky head result", 64'(out_result), 64'h7FFF_FFFF);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    checkOutput("flags head carry", 64'(out_carryout), 64'd1);
    checkOutput("flags head zero", 64'(out_zero), 64'd1);
    checkOutput("flags head op", 64'(out_op), 64'h8);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    checkOutput("sticky drained", 64'(count), 64'd0);

    // Async reset mid-operation.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b1, 1'b0, 4'h3, 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    checkOutput("pre-reset count", 64'(count), 64'd3);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async count", 64'(count), 64'd0);
    checkOutput("async empty", 64'(empty), 64'd1);
    checkOutput("async out_valid", 64'(out_valid), 64'd0);
    checkOutput("async sticky_ovf", 64'(sticky_ovf), 64'd0);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 4'h4, 1'b0, 1'b0);
    checkOutput("post-reset head", 64'(out_result), 64'hDEAD_BEEF);
    checkOutput("post-reset count", 64'(count), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
